p2s_serial_arbiter: RTL
=======================

// Module: p2s_serial_arbiter
// PURPOSE
//   Shares one LSB-first parallel-to-serial shifter between NUM_REQ requesters.
//   Round-robin arbitration picks a requester, loads its word and shifts it out
//   one bit per clock. Frames are tagged with the source ID and start/last marks.
//   Sits between parallel producers and a single-bit serial link.
// PARAMETERS
//   NUM_REQ     4   number of requesters (>=2)
//   DATA_WIDTH  4   bits per word (>=2)
// PORTS
//   clk         in   1                    clock; all state on posedge
//   resetn      in   1                    reset, asynchronous, active-low
//   req         in   NUM_REQ              per-requester word-pending request
//   din         in   NUM_REQ*DATA_WIDTH   words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   abort       in   1                    synchronous cancel of the current frame
//   gnt         out  NUM_REQ              one-hot, one-cycle acceptance pulse
//   dout        out  1                    serial data bit, LSB first
//   dout_valid  out  1                    dout carries a frame bit
//   frame_start out  1                    first bit of the frame
//   frame_last  out  1                    final bit of the frame
//   dout_src    out  $clog2(NUM_REQ)      ID of the requester being shifted
// BEHAVIOUR
//   - Reset (async, resetn=0): all outputs 0 immediately. State IDLE, shift reg 0,
//     bit count 0. RR pointer last_gnt = NUM_REQ-1, so requester 0 wins first.
//   - FSM IDLE -> SHIFT: on an edge in IDLE with |req, the RR pick loads din[winner]
//     into the shift reg, latches dout_src and sets last_gnt=winner.
//   - RR pick: first set req bit searching from last_gnt+1 upward, modulo NUM_REQ.
//   - Cycle after the load edge: gnt[winner]=1 (1 cycle only), dout=word[0],
//     dout_valid=1, frame_start=1. The requester must drop or change req by the next edge.
//   - SHIFT: each edge shifts right by 1 and increments the count. Bit k appears
//     k cycles after the first bit. frame_last=1 when count==FRAME_LEN-1.
//   - Last-bit cycle: with |req (abort=0), the next edge loads the next winner.
//     Back-to-back frames have no idle gap. Otherwise the next edge goes to IDLE.
//   - IDLE or after a frame: dout=0, dout_valid=0, frame_start/last=0,
//     dout_src holds its last value, gnt=0.
//   - abort=1 in SHIFT: next edge -> IDLE, shift reg cleared, no load on that edge
//     even with req pending. The aborted requester is not re-granted automatically.
//     abort in IDLE blocks the load on that edge.
//   - Async reset mid-frame drops the frame and restarts the RR pointer.
//   - Latency: req high in IDLE -> first bit on dout 1 cycle later.
// CONFIGURATION
//   P2S_ARB_PARITY_EN defined: FRAME_LEN=DATA_WIDTH+1. An even-parity bit
//     (^word) is shifted after the MSB, and frame_last marks the parity bit.
//   Not defined: FRAME_LEN=DATA_WIDTH, no parity bit.
// STRUCTURE
//   Package p2s_arb_pkg holds:
//     - state_t enum {IDLE, SHIFT};
//     - the rr_next_idx(req, last) pick function.
//   Sub-module p2s_rr_arbiter holds the combinational RR pick (req, last_gnt -> winner
//   index and any-valid). The FSM, shift reg, counter and output regs stay in the top level.
// TESTING (NUM_REQ=4, DATA_WIDTH=4)
//   1 req=0010, word1=4'b1011 -> gnt=0010 for 1 cycle; dout 1,1,0,1 with valid;
//     src=1; start on bit 0; last on bit 3.
//   2 req=1111 held, gnt released per grant -> grant order 0,1,2,3,0; 16 contiguous
//     valid cycles, no gaps.
//   3 abort during bit 2 of word 4'b1111 -> valid=0 and dout=0 next cycle;
//     pending req granted 1 cycle after that.
//   4 resetn=0 mid-frame between edges -> dout/valid/gnt 0 at once; after release
//     with req=0101 -> requester 0 granted first.
//   5 P2S_ARB_PARITY_EN, word 4'b0111 -> dout 1,1,1,0,1; last on 5th bit.
//   6 req=0000 for 20 cycles -> dout=0, valid=0, gnt=0 throughout.

Source files
------------

// File: rtl/p2s_arb_pkg.sv
// Shared types and helpers for the p2s_serial_arbiter slice.
// Optional build macro: P2S_ARB_PARITY_EN adds one even-parity bit after the MSB.
package p2s_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

`ifdef P2S_ARB_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Upper bound on requesters supported by the round-robin search.
    localparam int RR_MAX_REQ = 32;

    // Round-robin pick: returns the first set request bit searching upward from
    // last+1, wrapping modulo num_req. Walking offsets from far to near means the
    // nearest requester is written last and wins. Returns last when nothing is set.
    function automatic int rr_next_idx(input logic [RR_MAX_REQ-1:0] req,
                                       input int num_req,
                                       input int last);
        int pick;
        int idx;
        pick = last;
        for (int off = RR_MAX_REQ; off >= 1; off--) begin
            if (off <= num_req) begin
                idx = last + off;
                if (idx >= num_req) begin
                    idx = idx - num_req;
                end
                if (req[idx]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/p2s_serial_arbiter_rr.sv
// Combinational round-robin pick used by p2s_serial_arbiter.
// Build macro P2S_ARB_PARITY_EN has no effect on this block.
module p2s_rr_arbiter
    import p2s_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_gnt,
    output logic [IDX_W-1:0]   winner,
    output logic               any_valid
);

    logic [RR_MAX_REQ-1:0] req_ext;

    // Widen the request vector to the search width and pick the next owner after last_gnt.
    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req;
        winner                 = IDX_W'(rr_next_idx(req_ext, NUM_REQ, int'(last_gnt)));
        any_valid              = |req;
    end

endmodule

// File: rtl/p2s_serial_arbiter.sv
// Round-robin shared LSB-first parallel-to-serial shifter.
// Build macro P2S_ARB_PARITY_EN: frames carry DATA_WIDTH+1 bits, the last being
// even parity (^word); otherwise frames are exactly DATA_WIDTH bits.
module p2s_serial_arbiter
    import p2s_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] din,
    input  logic                          abort,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          dout,
    output logic                          dout_valid,
    output logic                          frame_start,
    output logic                          frame_last,
    output logic [$clog2(NUM_REQ)-1:0]    dout_src
);

    localparam int SRC_W     = $clog2(NUM_REQ);
    localparam int FRAME_LEN = DATA_WIDTH + PARITY_BITS;
    localparam int CNT_W     = $clog2(FRAME_LEN);

    state_t                 state_q, state_d;
    logic [FRAME_LEN-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [SRC_W-1:0]       last_gnt_q, last_gnt_d;
    logic [SRC_W-1:0]       src_q, src_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;

    logic [SRC_W-1:0]       winner;
    logic                   any_valid;
    logic [DATA_WIDTH-1:0]  sel_word;
    logic [FRAME_LEN-1:0]   load_word;
    logic                   is_last;
    logic                   do_load;

    p2s_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (SRC_W)
    ) u_rr (
        .req       (req),
        .last_gnt  (last_gnt_q),
        .winner    (winner),
        .any_valid (any_valid)
    );

    assign sel_word = din[winner*DATA_WIDTH +: DATA_WIDTH];

`ifdef P2S_ARB_PARITY_EN
    assign load_word = {^sel_word, sel_word};
`else
    assign load_word = sel_word;
`endif

    assign is_last = (count_q == CNT_W'(FRAME_LEN - 1));

    // Next-state logic: load a winner from IDLE or straight after the last bit, otherwise shift or drop to IDLE.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        count_d    = count_q;
        last_gnt_d = last_gnt_q;
        src_d      = src_q;
        gnt_d      = '0;
        do_load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!abort && any_valid) begin
                    do_load = 1'b1;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                    shift_d = '0;
                    count_d = '0;
                end else if (is_last) begin
                    if (any_valid) begin
                        do_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        shift_d = '0;
                        count_d = '0;
                    end
                end else begin
                    shift_d = shift_q >> 1;
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                shift_d = '0;
                count_d = '0;
            end
        endcase

        if (do_load) begin
            state_d    = SHIFT;
            shift_d    = load_word;
            count_d    = '0;
            last_gnt_d = winner;
            src_d      = winner;
            gnt_d      = NUM_REQ'(1) << winner;
        end
    end

    // State registers; the RR pointer resets to the top index so requester 0 wins first.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            count_q    <= '0;
            last_gnt_q <= SRC_W'(NUM_REQ - 1);
            src_q      <= '0;
            gnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            count_q    <= count_d;
            last_gnt_q <= last_gnt_d;
            src_q      <= src_d;
            gnt_q      <= gnt_d;
        end
    end

    // Outputs are decoded from registered state so reset clears them immediately.
    always_comb begin
        dout        = (state_q == SHIFT) & shift_q[0];
        dout_valid  = (state_q == SHIFT);
        frame_start = (state_q == SHIFT) && (count_q == '0);
        frame_last  = (state_q == SHIFT) && is_last;
        dout_src    = src_q;
        gnt         = gnt_q;
    end

endmodule
